// File: rtl/serial_adder_ctrl_if.sv
// Request/response bundle for serial_adder_ctrl: operands and start from the
// requester, busy/done and the registered result back from the controller.
interface serial_adder_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller: one full-adder cell plus a carry flop,
// processing one operand bit per clock, LSB first, over WIDTH cycles.
module serial_adder_ctrl_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_adder_ctrl_if.slave  bus
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] msb_bit;
  logic [WIDTH-1:0] res_next;

  serial_adder_ctrl_fa u_fa (
    .a_i (a_sh_q[0]),
    .b_i (b_sh_q[0]),
    .c_i (carry_q),
    .s_o (fa_s),
    .c_o (fa_c)
  );

  // The new sum bit enters at the MSB so that after WIDTH shifts the
  // register holds the fully assembled result in natural bit order.
  always_comb begin
    msb_bit            = '0;
    msb_bit[WIDTH-1]   = fa_s;
    res_next           = (res_sh_q >> 1) | msb_bit;
  end

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          a_sh_d   = bus.a;
          b_sh_d   = bus.sub ? ~bus.b : bus.b;
          carry_d  = bus.sub ? 1'b1 : bus.cin;
          res_sh_d = '0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_sh_d = res_next;
        carry_d  = fa_c;
        cnt_d    = cnt_q + CW'(1);
        // carry_q is the carry entering the MSB on this final bit
        if (cnt_q == LAST_BIT) begin
          sum_d   = res_next;
          cout_d  = fa_c;
          ovf_d   = carry_q ^ fa_c;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy = (state_q == S_RUN);
  assign bus.done = (state_q == S_DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized and directed bench for serial_adder_ctrl at WIDTH=8 and WIDTH=3,
// checked against an arithmetic reference model.
module tb_serial_adder_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_adder_ctrl_if #(.WIDTH(8)) bus8 ();
  serial_adder_ctrl_if #(.WIDTH(3)) bus3 ();

  serial_adder_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_adder_ctrl #(.WIDTH(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  int n_total = 0;
  int n_pass  = 0;
  logic [9:0] held;  // {ovf, cout, sum} last reported by the WIDTH=8 DUT

  // Returns {ovf, cout, sum[7:0]} for a w-bit operation using plain integers.
  function automatic logic [9:0] ref_model(input int w, input logic [7:0] a,
                                           input logic [7:0] b, input logic cin,
                                           input logic sub);
    longint mask, half, full, sa, sb, sr;
    logic [9:0] r;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    if (sub) full = longint'(a) + ((~longint'(b)) & mask) + 1;
    else     full = longint'(a) + longint'(b) + longint'(cin);
    sa = (longint'(a) >= half) ? longint'(a) - 2 * half : longint'(a);
    sb = (longint'(b) >= half) ? longint'(b) - 2 * half : longint'(b);
    sr = sub ? sa - sb : sa + sb + longint'(cin);
    r      = '0;
    r[7:0] = 8'(full & mask);
    r[8]   = full[w];
    r[9]   = (sr >= half) || (sr < -half);
    return r;
  endfunction

  task automatic do_op8(input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic sub, input string tag);
    logic [9:0] exp;
    logic [9:0] got;
    int busy_cycles;
    bit seen;
    exp = ref_model(8, a, b, cin, sub);
    @(negedge clk);
    bus8.a = a; bus8.b = b; bus8.cin = cin; bus8.sub = sub; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    bus8.a = 8'($urandom); bus8.b = 8'($urandom);
    bus8.cin = 1'($urandom); bus8.sub = 1'($urandom);
    busy_cycles = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus8.done) seen = 1;
      else begin
        if (bus8.busy) busy_cycles++;
        @(negedge clk);
      end
    end
    n_total++;
    if (seen !== 1'b1) $display("FAIL %s_done_timeout: got no done, expected done within 20 cycles", tag);
    else n_pass++;
    n_total++;
    if (busy_cycles !== 8) $display("FAIL %s_busy_len: got %0d expected 8", tag, busy_cycles);
    else n_pass++;
    n_total++;
    if (bus8.busy !== 1'b0) $display("FAIL %s_busy_at_done: got %b expected 0", tag, bus8.busy);
    else n_pass++;
    got = {bus8.ovf, bus8.cout, bus8.sum};
    n_total++;
    if (got !== exp) $display("FAIL %s_result: got ovf/cout/sum %h expected %h", tag, got, exp);
    else n_pass++;
    held = exp;
    @(negedge clk);
    n_total++;
    if (bus8.done !== 1'b0) $display("FAIL %s_done_pulse: got done=%b expected 0", tag, bus8.done);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0; bus8.sub = 1'b0;
    bus3.start = 1'b0; bus3.a = '0; bus3.b = '0; bus3.cin = 1'b0; bus3.sub = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({bus8.busy, bus8.done, bus8.cout, bus8.ovf, bus8.sum} !== 12'h000)
      $display("FAIL reset8: got busy/done/cout/ovf/sum %b%b%b%b %h expected all zero",
               bus8.busy, bus8.done, bus8.cout, bus8.ovf, bus8.sum);
    else n_pass++;
    n_total++;
    if ({bus3.busy, bus3.done, bus3.cout, bus3.ovf, bus3.sum} !== 7'h00)
      $display("FAIL reset3: got busy/done/cout/ovf/sum %b%b%b%b %h expected all zero",
               bus3.busy, bus3.done, bus3.cout, bus3.ovf, bus3.sum);
    else n_pass++;
    rst = 1'b0;
    held = '0;
  endtask

  task automatic test_directed();
    do_op8(8'h3C, 8'h5A, 1'b0, 1'b0, "add_ovf");
    do_op8(8'hFF, 8'h01, 1'b0, 1'b0, "wrap");
    do_op8(8'h00, 8'h00, 1'b1, 1'b0, "cin_only");
    do_op8(8'h10, 8'h20, 1'b0, 1'b1, "sub_borrow");
    do_op8(8'h80, 8'h01, 1'b1, 1'b1, "sub_ovf");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++)
      do_op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), "random");
  endtask

  task automatic test_back_to_back();
    logic [7:0] oa [0:44];
    logic [7:0] ob [0:44];
    logic       oc [0:44];
    logic       os [0:44];
    logic [9:0] exp;
    logic [9:0] got;
    int acc, last_done, pulses;
    acc = 0; last_done = -1; pulses = 0;
    for (int k = 0; k < 45; k++) begin
      oa[k] = 8'($urandom); ob[k] = 8'($urandom);
      oc[k] = 1'($urandom); os[k] = 1'($urandom);
      bus8.a = oa[k]; bus8.b = ob[k]; bus8.cin = oc[k]; bus8.sub = os[k];
      bus8.start = 1'b1;
      @(negedge clk);
      got = {bus8.ovf, bus8.cout, bus8.sum};
      if (bus8.done) begin
        exp = ref_model(8, oa[acc], ob[acc], oc[acc], os[acc]);
        n_total++;
        if (got !== exp) $display("FAIL b2b_result: got %h expected %h (op %0d)", got, exp, acc);
        else n_pass++;
        n_total++;
        if (k - acc !== 8) $display("FAIL b2b_latency: got %0d expected 8", k - acc);
        else n_pass++;
        if (last_done >= 0) begin
          n_total++;
          if (k - last_done !== 9) $display("FAIL b2b_interval: got %0d expected 9", k - last_done);
          else n_pass++;
        end
        last_done = k;
        acc = k + 1;
        pulses++;
        held = exp;
      end else begin
        n_total++;
        if (got !== held) $display("FAIL b2b_hold: got %h expected %h at cycle %0d", got, held, k);
        else n_pass++;
      end
    end
    bus8.start = 1'b0;
    @(negedge clk);
    n_total++;
    if (pulses !== 5) $display("FAIL b2b_pulses: got %0d expected 5", pulses);
    else n_pass++;
    n_total++;
    if ({bus8.busy, bus8.done} !== 2'b00) $display("FAIL b2b_idle: got busy/done %b%b expected 00", bus8.busy, bus8.done);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int dones;
    @(negedge clk);
    bus8.a = 8'h5A; bus8.b = 8'h3C; bus8.cin = 1'b1; bus8.sub = 1'b0; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_total++;
    if ({bus8.busy, bus8.done, bus8.cout, bus8.ovf, bus8.sum} !== 12'h000)
      $display("FAIL reset_mid_state: got busy/done/cout/ovf/sum %b%b%b%b %h expected all zero",
               bus8.busy, bus8.done, bus8.cout, bus8.ovf, bus8.sum);
    else n_pass++;
    held = '0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus8.done) dones++;
    end
    n_total++;
    if (dones !== 0) $display("FAIL reset_mid_no_done: got %0d pulses expected 0", dones);
    else n_pass++;
    do_op8(8'hC3, 8'h7E, 1'b0, 1'b1, "after_reset");
  endtask

  task automatic test_exhaustive3();
    logic [9:0] exp;
    logic [9:0] got;
    int lat;
    for (int ia = 0; ia < 8; ia++)
      for (int ib = 0; ib < 8; ib++)
        for (int ic = 0; ic < 2; ic++)
          for (int is = 0; is < 2; is++) begin
            exp = ref_model(3, 8'(ia), 8'(ib), 1'(ic), 1'(is));
            @(negedge clk);
            bus3.a = 3'(ia); bus3.b = 3'(ib); bus3.cin = 1'(ic); bus3.sub = 1'(is);
            bus3.start = 1'b1;
            @(negedge clk);
            bus3.start = 1'b0;
            bus3.a = 3'($urandom); bus3.b = 3'($urandom);
            lat = 1;
            while (!bus3.done && lat < 10) begin
              @(negedge clk);
              lat++;
            end
            got = {bus3.ovf, bus3.cout, 5'b0, bus3.sum};
            n_total++;
            if (lat !== 4) $display("FAIL w3_latency: got %0d expected 4 (a=%0d b=%0d cin=%0d sub=%0d)", lat, ia, ib, ic, is);
            else n_pass++;
            n_total++;
            if (got !== exp) $display("FAIL w3_result: got %h expected %h (a=%0d b=%0d cin=%0d sub=%0d)", got, exp, ia, ib, ic, is);
            else n_pass++;
          end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_exhaustive3();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
